// File: rtl/motor_speed_arbiter_pkg.sv
// Shared speed-level and ownership encodings for the motor speed path and PWM generators.
// Latency: none (types only).
// Backpressure: not applicable.
package motor_pkg;

    typedef enum logic [1:0] {
        SPD_STOP    = 2'd0,
        SPD_SLOW    = 2'd1,
        SPD_FAST    = 2'd2,
        SPD_FASTEST = 2'd3
    } speed_level_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_MAN  = 2'd1,
        OWN_NAV  = 2'd2
    } owner_t;

endpackage

// File: rtl/motor_speed_arbiter_ramp.sv
// One-level ramp step for a single motor: moves current toward target on a tick.
// Latency: combinational.
// Backpressure: none; saturates at the target, so it never overshoots or wraps.
module motor_ramp_step (
    input  logic [1:0] target_i,
    input  logic [1:0] current_i,
    input  logic       tick_i,
    output logic [1:0] next_o,
    output logic       changed_o
);

    // Step one level toward the target only when a ramp tick is present.
    always_comb begin
        next_o = current_i;
        if (tick_i) begin
            if (current_i < target_i) begin
                next_o = current_i + 2'd1;
            end else if (current_i > target_i) begin
                next_o = current_i - 2'd1;
            end
        end
        changed_o = (next_o != current_i);
    end

endmodule

// File: rtl/motor_speed_arbiter.sv
// Arbitrates manual vs navigation speed commands, ramps each motor toward its target, nav watchdog.
// Latency: command latched one cycle after transfer; speed steps on free-running ramp ticks.
// Backpressure: acks are combinational from req and owner; manual always wins, nav waits while MAN owns.
module motor_speed_arbiter
    import motor_pkg::*;
#(
    parameter int RAMP_CYCLES    = 256,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       man_req,
    input  logic [1:0] man_speed_l,
    input  logic [1:0] man_speed_r,
    output logic       man_ack,
    input  logic       nav_req,
    input  logic [1:0] nav_speed_l,
    input  logic [1:0] nav_speed_r,
    output logic       nav_ack,
    output logic [1:0] speed_l,
    output logic [1:0] speed_r,
    output logic       speed_update,
    output logic [1:0] owner,
    output logic       ramping,
    output logic       wdog_trip
);

    localparam int TICK_W = (RAMP_CYCLES > 2) ? $clog2(RAMP_CYCLES) : 1;
    localparam int WD_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(RAMP_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    owner_t            owner_q, owner_d;
    logic [1:0]        tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
    logic [1:0]        spd_l_q, spd_l_d, spd_r_q, spd_r_d;
    logic              upd_q, upd_d;
    logic              trip_q, trip_d;

    logic              man_xfer, nav_xfer, tick, trip_cond, force_stop, idle;
    logic [1:0]        step_l, step_r;
    logic              chg_l, chg_r;

    assign man_ack  = man_req;
    assign nav_ack  = nav_req & ~man_req & (owner_q != OWN_MAN);
    assign man_xfer = man_ack;
    assign nav_xfer = nav_ack;

    assign tick       = (tick_q == '0);
    // Nav went silent too long; a same-cycle manual command takes over instead of stopping.
    assign trip_cond  = (owner_q == OWN_NAV) && (wd_q == WD_LAST) && !nav_xfer;
    assign force_stop = trip_cond && !man_xfer;
    assign idle       = (tgt_l_q == 2'd0) && (tgt_r_q == 2'd0) &&
                        (spd_l_q == 2'd0) && (spd_r_q == 2'd0);

    motor_ramp_step u_ramp_l (
        .target_i  (tgt_l_q),
        .current_i (spd_l_q),
        .tick_i    (tick),
        .next_o    (step_l),
        .changed_o (chg_l)
    );

    motor_ramp_step u_ramp_r (
        .target_i  (tgt_r_q),
        .current_i (spd_r_q),
        .tick_i    (tick),
        .next_o    (step_r),
        .changed_o (chg_r)
    );

    // Next-state for targets, speeds, owner FSM, tick and watchdog counters.
    always_comb begin
        tgt_l_d = tgt_l_q;
        tgt_r_d = tgt_r_q;
        spd_l_d = step_l;
        spd_r_d = step_r;
        upd_d   = chg_l | chg_r;
        trip_d  = force_stop;
        owner_d = owner_q;
        tick_d  = tick ? TICK_RELOAD : tick_q - 1'b1;

        if (man_xfer) begin
            tgt_l_d = man_speed_l;
            tgt_r_d = man_speed_r;
        end else if (nav_xfer) begin
            tgt_l_d = nav_speed_l;
            tgt_r_d = nav_speed_r;
        end else if (force_stop) begin
            tgt_l_d = SPD_STOP;
            tgt_r_d = SPD_STOP;
        end

        // A watchdog stop bypasses the ramp entirely.
        if (force_stop) begin
            spd_l_d = SPD_STOP;
            spd_r_d = SPD_STOP;
            upd_d   = (spd_l_q != 2'd0) || (spd_r_q != 2'd0);
        end

        case (owner_q)
            OWN_NONE: begin
                if (man_xfer)      owner_d = OWN_MAN;
                else if (nav_xfer) owner_d = OWN_NAV;
            end
            OWN_MAN: begin
                if (!man_xfer && idle) owner_d = OWN_NONE;
            end
            OWN_NAV: begin
                if (man_xfer)        owner_d = OWN_MAN;
                else if (force_stop) owner_d = OWN_NONE;
                else if (!nav_xfer && idle) owner_d = OWN_NONE;
            end
            default: owner_d = OWN_NONE;
        endcase

        // Watchdog only runs while nav stays in control and is quiet.
        if (owner_d != OWN_NAV || nav_xfer) wd_d = '0;
        else                                 wd_d = wd_q + 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= TICK_RELOAD;
            wd_q    <= '0;
            owner_q <= OWN_NONE;
            tgt_l_q <= SPD_STOP;
            tgt_r_q <= SPD_STOP;
            spd_l_q <= SPD_STOP;
            spd_r_q <= SPD_STOP;
            upd_q   <= 1'b0;
            trip_q  <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            wd_q    <= wd_d;
            owner_q <= owner_d;
            tgt_l_q <= tgt_l_d;
            tgt_r_q <= tgt_r_d;
            spd_l_q <= spd_l_d;
            spd_r_q <= spd_r_d;
            upd_q   <= upd_d;
            trip_q  <= trip_d;
        end
    end

    assign speed_l      = spd_l_q;
    assign speed_r      = spd_r_q;
    assign speed_update = upd_q;
    assign owner        = owner_q;
    assign wdog_trip    = trip_q;
    assign ramping      = (spd_l_q != tgt_l_q) | (spd_r_q != tgt_r_q);

endmodule

// File: tb/tb_motor_speed_arbiter.sv
// Directed bench for motor_speed_arbiter with RAMP_CYCLES=4, TIMEOUT_CYCLES=32.
// Inputs driven on the falling edge; outputs sampled on the falling edge (acks #1 after driving).
// Each scenario task does its own comparisons and steps the shared counters.
module tb_motor_speed_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       man_req = 1'b0;
    logic [1:0] man_speed_l = 2'd0, man_speed_r = 2'd0;
    logic       man_ack;
    logic       nav_req = 1'b0;
    logic [1:0] nav_speed_l = 2'd0, nav_speed_r = 2'd0;
    logic       nav_ack;
    logic [1:0] speed_l, speed_r;
    logic       speed_update;
    logic [1:0] owner;
    logic       ramping;
    logic       wdog_trip;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    motor_speed_arbiter #(.RAMP_CYCLES(4), .TIMEOUT_CYCLES(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .man_req      (man_req),
        .man_speed_l  (man_speed_l),
        .man_speed_r  (man_speed_r),
        .man_ack      (man_ack),
        .nav_req      (nav_req),
        .nav_speed_l  (nav_speed_l),
        .nav_speed_r  (nav_speed_r),
        .nav_ack      (nav_ack),
        .speed_l      (speed_l),
        .speed_r      (speed_r),
        .speed_update (speed_update),
        .owner        (owner),
        .ramping      (ramping),
        .wdog_trip    (wdog_trip)
    );

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({speed_l, speed_r, owner, speed_update, wdog_trip, ramping} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_state: got l=%0d r=%0d own=%0d upd=%0b trip=%0b ramp=%0b, want all 0",
                     speed_l, speed_r, owner, speed_update, wdog_trip, ramping);
        end
        reset = 1'b0;
    endtask

    // Cycle c1 is the one in which reset is released; ticks land at the end of c4, c8, c12.
    task automatic test_nav_ramp();
        int ups;
        logic [1:0] exp_spd;
        logic       exp_upd;
        ups = 0;
        nav_req = 1'b1; nav_speed_l = 2'd3; nav_speed_r = 2'd3;
        #1;
        n_cmp++;
        if (nav_ack !== 1'b1) begin
            n_bad++; $display("FAIL nav_ack_idle: got %0b want 1", nav_ack);
        end
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2) begin
                nav_req = 1'b0;
                n_cmp++;
                if (owner !== 2'd2) begin
                    n_bad++; $display("FAIL owner_nav: got %0d want 2", owner);
                end
            end
            exp_spd = (k < 5) ? 2'd0 : (k < 9) ? 2'd1 : (k < 13) ? 2'd2 : 2'd3;
            exp_upd = (k == 5) || (k == 9) || (k == 13);
            if (speed_update) ups++;
            n_cmp++;
            if (speed_l !== exp_spd || speed_r !== exp_spd || speed_update !== exp_upd) begin
                n_bad++;
                $display("FAIL ramp_up c%0d: got l=%0d r=%0d upd=%0b want %0d/%0d upd=%0b",
                         k, speed_l, speed_r, speed_update, exp_spd, exp_spd, exp_upd);
            end
        end
        n_cmp++;
        if (ups !== 3) begin
            n_bad++; $display("FAIL ramp_up_pulses: got %0d want 3", ups);
        end
    endtask

    task automatic test_same_cycle();
        man_req = 1'b1; man_speed_l = 2'd1; man_speed_r = 2'd1;
        nav_req = 1'b1; nav_speed_l = 2'd3; nav_speed_r = 2'd3;
        #1;
        n_cmp++;
        if (man_ack !== 1'b1 || nav_ack !== 1'b0) begin
            n_bad++; $display("FAIL both_req_acks: got man=%0b nav=%0b want 1/0", man_ack, nav_ack);
        end
        @(negedge clk);
        man_req = 1'b0;
        #1;
        n_cmp++;
        if (owner !== 2'd1) begin
            n_bad++; $display("FAIL owner_man: got %0d want 1", owner);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (nav_ack !== 1'b0) begin
                n_bad++; $display("FAIL nav_blocked_%0d: got %0b want 0", k, nav_ack);
            end
        end
    endtask

    task automatic test_manual_stop();
        int exp_l;
        bit done;
        man_req = 1'b1; man_speed_l = 2'd3; man_speed_r = 2'd3;
        @(negedge clk);
        man_req = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!ramping && speed_l == 2'd3 && speed_r == 2'd3) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++; $display("FAIL man_reach_3: got l=%0d r=%0d want 3/3", speed_l, speed_r);
        end
        man_req = 1'b1; man_speed_l = 2'd0; man_speed_r = 2'd0;
        @(negedge clk);
        man_req = 1'b0;
        exp_l = 2;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (speed_update) begin
                n_cmp++;
                if (speed_l !== 2'(exp_l) || speed_r !== 2'(exp_l)) begin
                    n_bad++;
                    $display("FAIL ramp_down: got l=%0d r=%0d want %0d", speed_l, speed_r, exp_l);
                end
                if (exp_l == 0) begin
                    done = 1'b1;
                    n_cmp++;
                    if (owner !== 2'd1) begin
                        n_bad++; $display("FAIL owner_at_zero: got %0d want 1", owner);
                    end
                end
                exp_l--;
            end
            if (!done) @(negedge clk);
        end
        n_cmp++;
        if (!done) begin
            n_bad++; $display("FAIL ramp_down_timeout: got l=%0d want 0", speed_l);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (owner !== 2'd0 || nav_ack !== 1'b1) begin
            n_bad++; $display("FAIL release_to_nav: got own=%0d nav_ack=%0b want 0/1", owner, nav_ack);
        end
    endtask

    // Nav transfer in cycle T; watchdog reaches 31 in T+32, trip visible in T+33.
    task automatic test_watchdog();
        bit early;
        @(negedge clk);
        nav_req = 1'b1; nav_speed_l = 2'd2; nav_speed_r = 2'd2;
        #1;
        n_cmp++;
        if (nav_ack !== 1'b1) begin
            n_bad++; $display("FAIL nav_ack_22: got %0b want 1", nav_ack);
        end
        early = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) nav_req = 1'b0;
            if (k < 33 && wdog_trip) early = 1'b1;
            if (k == 32) begin
                n_cmp++;
                if (speed_l !== 2'd2 || speed_r !== 2'd2 || owner !== 2'd2) begin
                    n_bad++;
                    $display("FAIL pre_trip: got l=%0d r=%0d own=%0d want 2/2 own 2", speed_l, speed_r, owner);
                end
            end
            if (k == 33) begin
                n_cmp++;
                if (wdog_trip !== 1'b1 || speed_l !== 2'd0 || speed_r !== 2'd0 ||
                    owner !== 2'd0 || speed_update !== 1'b1) begin
                    n_bad++;
                    $display("FAIL trip: got trip=%0b l=%0d r=%0d own=%0d upd=%0b want 1 0 0 0 1",
                             wdog_trip, speed_l, speed_r, owner, speed_update);
                end
            end
            if (k == 34) begin
                n_cmp++;
                if (wdog_trip !== 1'b0) begin
                    n_bad++; $display("FAIL trip_pulse_width: got %0b want 0", wdog_trip);
                end
            end
        end
        n_cmp++;
        if (early) begin
            n_bad++; $display("FAIL trip_early: got early trip want none");
        end
    endtask

    task automatic test_back_to_back();
        bit tripped;
        int n;
        tripped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nav_req = 1'b1; nav_speed_l = 2'd2; nav_speed_r = 2'd2;
            #1;
            n_cmp++;
            if (nav_ack !== 1'b1) begin
                n_bad++; $display("FAIL refresh_ack_%0d: got %0b want 1", i, nav_ack);
            end
            for (int j = 1; j <= 19; j++) begin
                @(negedge clk);
                if (j == 1) nav_req = 1'b0;
                if (wdog_trip) tripped = 1'b1;
            end
        end
        n_cmp++;
        if (tripped || speed_l !== 2'd2 || speed_r !== 2'd2) begin
            n_bad++;
            $display("FAIL refresh: got trip=%0b l=%0d r=%0d want 0 2/2", tripped, speed_l, speed_r);
        end
        @(negedge clk);
        nav_req = 1'b1; nav_speed_l = 2'd3; nav_speed_r = 2'd0;
        n = 0;
        for (int k = 0; k < 14 && n < 2; k++) begin
            @(negedge clk);
            nav_req = 1'b0;
            if (speed_update) begin
                n_cmp++;
                if (n == 0 && (speed_l !== 2'd3 || speed_r !== 2'd1)) begin
                    n_bad++; $display("FAIL split_step1: got %0d/%0d want 3/1", speed_l, speed_r);
                end
                if (n == 1 && (speed_l !== 2'd3 || speed_r !== 2'd0)) begin
                    n_bad++; $display("FAIL split_step2: got %0d/%0d want 3/0", speed_l, speed_r);
                end
                n++;
            end
        end
        n_cmp++;
        if (n !== 2) begin
            n_bad++; $display("FAIL split_steps: got %0d updates want 2", n);
        end
    endtask

    task automatic test_reset_mid_ramp();
        bit seen;
        @(negedge clk);
        nav_req = 1'b1; nav_speed_l = 2'd0; nav_speed_r = 2'd0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            nav_req = 1'b0;
            if (speed_l == 2'd2) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL mid_ramp_reach_2: got l=%0d want 2", speed_l);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (speed_l !== 2'd0 || speed_r !== 2'd0 || owner !== 2'd0 ||
            speed_update !== 1'b0 || ramping !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_ramp_reset: got l=%0d r=%0d own=%0d upd=%0b ramp=%0b want all 0",
                     speed_l, speed_r, owner, speed_update, ramping);
        end
        reset = 1'b0;
        nav_req = 1'b1; nav_speed_l = 2'd1; nav_speed_r = 2'd1;
        #1;
        n_cmp++;
        if (nav_ack !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_nav_ack: got %0b want 1", nav_ack);
        end
        man_req = 1'b1; man_speed_l = 2'd2; man_speed_r = 2'd2;
        #1;
        n_cmp++;
        if (man_ack !== 1'b1 || nav_ack !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_both: got man=%0b nav=%0b want 1/0", man_ack, nav_ack);
        end
        @(negedge clk);
        man_req = 1'b0; nav_req = 1'b0;
        #1;
        n_cmp++;
        if (owner !== 2'd1) begin
            n_bad++; $display("FAIL post_reset_owner: got %0d want 1", owner);
        end
    endtask

    initial begin
        test_reset();
        test_nav_ramp();
        test_same_cycle();
        test_manual_stop();
        test_watchdog();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
